// File: rtl/div_scheduler.sv
// div_scheduler
// Shares one iterative divider between NUM_REQ requesters. A round-robin
// arbiter picks one request in IDLE, the operands are handed to the divider
// (or short-circuited for a zero divisor), and the result is returned to the
// granted requester with a valid/ready handshake.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           per-requester request handshake
//   req_left/req_right            packed dividends/divisors, slice i*WORD_WIDTH
//   resp_valid/resp_ready         per-requester response handshake
//   resp_quot/resp_mod/resp_err   shared response data
//   div_enable/div_left/div_right request to the shared divider
//   div_valid/div_quot/div_mod    result from the shared divider
//   busy                          high whenever not idle
//
// state   | meaning
// IDLE    | arbitrating, req_ready offered to the round-robin winner
// ISSUE   | div_enable high, waiting for div_valid or timeout
// RELEASE | div_enable low, waiting for the divider to drop div_valid
// RESP    | resp_valid to the granted requester until it accepts
module div_scheduler #(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_left,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_right,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [WORD_WIDTH-1:0]         resp_quot,
    output logic [WORD_WIDTH-1:0]         resp_mod,
    output logic                          resp_err,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic                          div_enable,
    output logic [WORD_WIDTH-1:0]         div_left,
    output logic [WORD_WIDTH-1:0]         div_right,
    input  logic                          div_valid,
    input  logic [WORD_WIDTH-1:0]         div_quot,
    input  logic [WORD_WIDTH-1:0]         div_mod,
    output logic                          busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [GW-1:0]         r_last_grant;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         w_win;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_timeout;
    logic                  w_resp_done;

    logic [WORD_WIDTH-1:0] w_left  [NUM_REQ];
    logic [WORD_WIDTH-1:0] w_right [NUM_REQ];

    logic [WORD_WIDTH-1:0] r_left;
    logic [WORD_WIDTH-1:0] r_right;
    logic [WORD_WIDTH-1:0] r_quot;
    logic [WORD_WIDTH-1:0] r_mod;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_left[gi]  = req_left[gi*WORD_WIDTH +: WORD_WIDTH];
        assign w_right[gi] = req_right[gi*WORD_WIDTH +: WORD_WIDTH];
    end

    // Round-robin: walk from the farthest candidate back to last_grant+1 so
    // the nearest asserted requester after last_grant is the one that sticks.
    always_comb begin : p_arb
        int            idx;
        logic [GW-1:0] cand;
        idx   = 0;
        cand  = '0;
        w_win = r_last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = GW'(idx);
            if (req_valid[cand]) begin
                w_win = cand;
            end
        end
    end

    assign w_any       = |req_valid;
    assign w_accept    = (r_state == S_IDLE) && w_any;
    assign w_div_zero  = (w_right[w_win] == '0);
    assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));
    assign w_resp_done = resp_ready[r_grant];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_div_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (div_valid || w_timeout) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!div_valid) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_resp_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register, so reset clears them at once
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        div_enable = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  req_ready[w_win]    = w_any;
            S_ISSUE: div_enable          = 1'b1;
            S_RESP:  resp_valid[r_grant] = 1'b1;
            default: ;
        endcase
    end

    // Datapath: grant bookkeeping, operand hold, result capture, timeout count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant      <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_quot       <= '0;
            r_mod        <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_grant      <= w_win;
                r_last_grant <= w_win;
                if (w_div_zero) begin
                    r_quot <= '1;
                    r_mod  <= w_left[w_win];
                    r_err  <= 1'b1;
                end else begin
                    r_left  <= w_left[w_win];
                    r_right <= w_right[w_win];
                    r_cnt   <= '0;
                end
            end else if (r_state == S_ISSUE) begin
                if (div_valid) begin
                    r_quot <= div_quot;
                    r_mod  <= div_mod;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_quot <= '0;
                    r_mod  <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign div_left  = r_left;
    assign div_right = r_right;
    assign resp_quot = r_quot;
    assign resp_mod  = r_mod;
    assign resp_err  = r_err;

endmodule

// File: tb/tb_div_scheduler.sv
// Testbench for div_scheduler: a transaction-level reference model tracks the
// expected handshake and result of each operation, a compare process checks
// the DUT against it every cycle, and directed sequences pin literal values.
module tb_div_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_left = '0;
    logic [N*W-1:0] req_right = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_quot;
    logic [W-1:0]   resp_mod;
    logic           resp_err;
    logic [N-1:0]   resp_ready = '0;
    logic           div_enable;
    logic [W-1:0]   div_left;
    logic [W-1:0]   div_right;
    logic           div_valid = 1'b0;
    logic [W-1:0]   div_quot = '0;
    logic [W-1:0]   div_mod = '0;
    logic           busy;

    int tests = 0;
    int fails = 0;

    // divider model configuration
    int cfg_delay = 0;
    bit cfg_never = 1'b0;
    int cfg_hold  = 0;

    div_scheduler #(.WORD_WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_left   (req_left),
        .req_right  (req_right),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_quot  (resp_quot),
        .resp_mod   (resp_mod),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .div_enable (div_enable),
        .div_left   (div_left),
        .div_right  (div_right),
        .div_valid  (div_valid),
        .div_quot   (div_quot),
        .div_mod    (div_mod),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    localparam int PH_FREE = 0, PH_DIV = 1, PH_DRAIN = 2, PH_OUT = 3;
    int         m_phase  = PH_FREE;
    int         m_last   = N - 1;
    int         m_owner  = 0;
    int         m_cycles = 0;
    int         m_a = 0, m_b = 0;
    logic [W-1:0] m_q = '0, m_m = '0;
    logic         m_e = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = PH_FREE;
            m_last  = N - 1;
            m_q = '0; m_m = '0; m_e = 1'b0;
        end else begin
            case (m_phase)
                PH_FREE: begin
                    int w;
                    w = rr_pick(m_last, req_valid);
                    if (w >= 0) begin
                        m_last  = w;
                        m_owner = w;
                        m_a = int'(req_left[w*W +: W]);
                        m_b = int'(req_right[w*W +: W]);
                        if (m_b == 0) begin
                            m_q = '1; m_m = W'(m_a); m_e = 1'b1;
                            m_phase = PH_OUT;
                        end else begin
                            m_cycles = 0;
                            m_phase  = PH_DIV;
                        end
                    end
                end
                PH_DIV: begin
                    m_cycles++;
                    if (div_valid) begin
                        m_q = W'(m_a / m_b); m_m = W'(m_a % m_b); m_e = 1'b0;
                        m_phase = PH_DRAIN;
                    end else if (m_cycles == TO) begin
                        m_q = '0; m_m = '0; m_e = 1'b1;
                        m_phase = PH_DRAIN;
                    end
                end
                PH_DRAIN: if (!div_valid) m_phase = PH_OUT;
                default:  if (resp_ready[m_owner]) m_phase = PH_FREE;
            endcase
        end
    end

    // every-cycle compare against the model
    always @(negedge clk) begin
        logic [N-1:0] e_rr, e_rv;
        int w;
        e_rr = '0;
        e_rv = '0;
        w = rr_pick(m_last, req_valid);
        if (m_phase == PH_FREE && w >= 0) e_rr[w] = 1'b1;
        if (m_phase == PH_OUT) e_rv[m_owner] = 1'b1;
        check("req_ready", req_ready, e_rr);
        check("resp_valid", resp_valid, e_rv);
        check("busy", busy, (m_phase != PH_FREE));
        check("div_enable", div_enable, (m_phase == PH_DIV));
        if (m_phase == PH_OUT) begin
            check("resp_quot", resp_quot, m_q);
            check("resp_mod", resp_mod, m_m);
            check("resp_err", resp_err, m_e);
        end
        if (m_phase == PH_DIV) begin
            check("div_left", div_left, m_a);
            check("div_right", div_right, m_b);
        end
    end

    // ---------------- divider model ----------------
    int dv_cnt = 0;
    int dv_hold = 0;
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                div_valid = 1'b0;
                dv_cnt = 0;
                dv_hold = 0;
            end else begin
                #1;
                if (div_valid) begin
                    if (!div_enable) begin
                        if (dv_hold == 0) div_valid = 1'b0;
                        else dv_hold--;
                    end
                end else if (div_enable) begin
                    if (!cfg_never) begin
                        if (dv_cnt >= cfg_delay) begin
                            div_valid = 1'b1;
                            div_quot  = (div_right == '0) ? '1 : div_left / div_right;
                            div_mod   = (div_right == '0) ? '0 : div_left % div_right;
                            dv_cnt    = 0;
                            dv_hold   = cfg_hold;
                        end else begin
                            dv_cnt++;
                        end
                    end
                end else begin
                    dv_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_left[i*W +: W]  = W'(a);
        req_right[i*W +: W] = W'(b);
    endtask

    task automatic wait_resp(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (|resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_resp: got no resp_valid, expected one within %0d cycles", bound);
        end
    endtask

    task automatic ack(input int i);
        tick();
        resp_ready = '0;
        resp_ready[i] = 1'b1;
        tick();
        resp_ready = '0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", ok, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int en_cnt;
        int grants[5];
        int ng;

        // reset values
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_div_enable", div_enable, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_quot", resp_quot, 0);
        check("rst_resp_mod", resp_mod, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_div_left", div_left, 0);
        check("rst_div_right", div_right, 0);
        tick();
        reset_n = 1'b1;

        // single request 100/7 on requester 0
        cfg_delay = 19; cfg_never = 1'b0; cfg_hold = 0;
        tick();
        set_req(0, 100, 7);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        wait_resp(100, ok);
        check("single_resp_valid", resp_valid, 4'b0001);
        check("single_quot", resp_quot, 14);
        check("single_mod", resp_mod, 2);
        check("single_err", resp_err, 0);
        ack(0);

        // divide by zero on requester 2
        set_req(2, 55, 0);
        req_valid = 4'b0100;
        @(negedge clk);
        check("dz_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("dz_resp_valid", resp_valid, 4'b0100);
        check("dz_div_enable", div_enable, 0);
        check("dz_quot", resp_quot, 255);
        check("dz_mod", resp_mod, 55);
        check("dz_err", resp_err, 1);
        ack(2);

        // timeout: divider never answers
        cfg_never = 1'b1;
        set_req(1, 200, 3);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        en_cnt = 0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (div_enable) en_cnt++;
            if (|resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_resp_seen", ok, 1);
        check("to_enable_cycles", en_cnt, 64);
        check("to_resp_valid", resp_valid, 4'b0010);
        check("to_quot", resp_quot, 0);
        check("to_mod", resp_mod, 0);
        check("to_err", resp_err, 1);
        ack(1);
        cfg_never = 1'b0;

        // backpressure on requester 3 with requester 0 waiting
        cfg_delay = 2;
        set_req(3, 9, 4);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        wait_resp(100, ok);
        for (int c = 0; c < 10; c++) begin
            tick();
            req_valid = 4'b0001;
            resp_ready = 4'b0111;
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 4'b1000);
            check("bp_quot", resp_quot, 2);
            check("bp_mod", resp_mod, 1);
            check("bp_err", resp_err, 0);
            check("bp_req_ready", req_ready, 0);
        end
        tick();
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;
        @(negedge clk);
        check("b2b_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp(100, ok);
        check("b2b_resp_valid", resp_valid, 4'b0001);
        ack(0);

        // reset in the middle of ISSUE
        cfg_never = 1'b1;
        set_req(1, 50, 5);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (5) @(negedge clk);
        check("mid_div_enable_before", div_enable, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_div_enable", div_enable, 0);
        check("mid_busy", busy, 0);
        check("mid_resp_valid", resp_valid, 0);
        cfg_never = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;

        // contention: all requesters hold req_valid
        cfg_delay = 1;
        for (int i = 0; i < N; i++) set_req(i, 10 * i + 20, i + 3);
        resp_ready = 4'hF;
        req_valid  = 4'hF;
        ng = 0;
        for (int c = 0; c < 500 && ng < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (req_ready[i]) begin
                grants[ng] = i;
                ng++;
            end
        end
        tick();
        req_valid = '0;
        check("cont_grant_count", ng, 5);
        for (int k = 0; k < 5; k++) check("cont_grant_order", grants[k], k % N);
        wait_idle(200);
        resp_ready = '0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                set_req(i, int'($urandom_range(0, 255)),
                        ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
            end
            req_valid  = N'($urandom_range(0, 15));
            resp_ready = N'($urandom_range(0, 15));
            if (!div_enable && !div_valid) begin
                cfg_delay = int'($urandom_range(0, 8));
                cfg_never = ($urandom_range(0, 15) == 0);
                cfg_hold  = int'($urandom_range(0, 3));
            end
        end
        req_valid  = '0;
        resp_ready = 4'hF;
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
